// File: rtl/irq_ctrl.sv
// irq_ctrl: Wishbone-slave interrupt controller.
//   Each request line on int_i is synchronised through a two-flop input stage,
//   then captured into a pending register as either a rising edge (ITR bit = 1)
//   or a level (ITR bit = 0). The CPU request irq is asserted when the master
//   enable is set and any pending source is also enabled. Bit 0 has the
//   highest priority in the vector register.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   int_i[INTw]           interrupt request lines
//   sa_dat_i / sa_dat_o   write data in / registered read data out
//   sa_addr_i             word address (0 MER, 1 IER, 2 IAR, 3 IPR, 4 ISR,
//                         5 ITR, 6 IVR, 7 reserved)
//   sa_stb_i, sa_we_i     strobe, write enable
//   sa_cyc_i, sa_sel_i,
//   sa_tag_i              accepted but unused (full-word access only)
//   sa_ack_o              one-cycle acknowledge per strobe
//   sa_err_o, sa_rty_o    always 0
//   irq                   registered interrupt request to the CPU
module irq_ctrl #(
   parameter int INTw = 4,
   parameter int Dw   = 32,
   parameter int Aw   = 3,
   parameter int SELw = 4,
   parameter int TAGw = 3
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [INTw-1:0] int_i,
   input  logic [Dw-1:0]   sa_dat_i,
   input  logic [SELw-1:0] sa_sel_i,
   input  logic [Aw-1:0]   sa_addr_i,
   input  logic [TAGw-1:0] sa_tag_i,
   input  logic            sa_stb_i,
   input  logic            sa_cyc_i,
   input  logic            sa_we_i,
   output logic [Dw-1:0]   sa_dat_o,
   output logic            sa_ack_o,
   output logic            sa_err_o,
   output logic            sa_rty_o,
   output logic            irq
);

   localparam int IDXW = (INTw > 1) ? $clog2(INTw) : 1;

   localparam logic [Aw-1:0] A_MER = Aw'(0);
   localparam logic [Aw-1:0] A_IER = Aw'(1);
   localparam logic [Aw-1:0] A_IAR = Aw'(2);
   localparam logic [Aw-1:0] A_IPR = Aw'(3);
   localparam logic [Aw-1:0] A_ISR = Aw'(4);
   localparam logic [Aw-1:0] A_ITR = Aw'(5);
   localparam logic [Aw-1:0] A_IVR = Aw'(6);

   logic            mer_q, mer_d;
   logic [INTw-1:0] ier_q, ier_d;
   logic [INTw-1:0] itr_q, itr_d;
   logic [INTw-1:0] ipr_q, ipr_d;
   logic [INTw-1:0] int_s_q, int_p_q;
   logic [Dw-1:0]   dat_q, dat_d;
   logic            ack_q, ack_d;
   logic            irq_q, irq_d;

   logic            wr_en, rd_en;
   logic [INTw-1:0] iar_clr;
   logic [INTw-1:0] rise;
   logic [INTw-1:0] isr;
   logic [IDXW-1:0] ivr_idx;
   logic [Dw-1:0]   ivr;

   logic unused_inputs;
   assign unused_inputs = ^{sa_sel_i, sa_tag_i, sa_cyc_i, sa_dat_i[Dw-1:INTw]};

   assign wr_en = sa_stb_i & sa_we_i;
   assign rd_en = sa_stb_i & ~sa_we_i;
   assign rise  = int_s_q & ~int_p_q;
   assign isr   = ipr_q & ier_q;

   // Lowest-numbered active source wins: scan high to low so the last hit
   // (lowest index) is the one that sticks.
   always_comb begin
      ivr_idx = '0;
      for (int i = INTw - 1; i >= 0; i--) begin
         if (isr[i]) ivr_idx = IDXW'(i);
      end
      ivr = '0;
      if (|isr) begin
         ivr[IDXW-1:0] = ivr_idx;
         ivr[Dw-1]     = 1'b1;
      end
   end

   always_comb begin
      mer_d   = mer_q;
      ier_d   = ier_q;
      itr_d   = itr_q;
      iar_clr = '0;
      if (wr_en) begin
         case (sa_addr_i)
            A_MER:   mer_d   = sa_dat_i[0];
            A_IER:   ier_d   = sa_dat_i[INTw-1:0];
            A_IAR:   iar_clr = sa_dat_i[INTw-1:0];
            A_ITR:   itr_d   = sa_dat_i[INTw-1:0];
            default: ;
         endcase
      end

      // Edge sources: a rise sets, IAR clears, set beats clear.
      // Level sources simply track the synchronised input.
      ipr_d = (itr_q & (rise | (ipr_q & ~iar_clr))) | (~itr_q & int_s_q);

      irq_d = mer_q & (|isr);
      ack_d = sa_stb_i & ~ack_q;

      dat_d = dat_q;
      if (rd_en) begin
         case (sa_addr_i)
            A_MER:   dat_d = Dw'(mer_q);
            A_IER:   dat_d = Dw'(ier_q);
            A_IPR:   dat_d = Dw'(ipr_q);
            A_ISR:   dat_d = Dw'(isr);
            A_ITR:   dat_d = Dw'(itr_q);
            A_IVR:   dat_d = ivr;
            default: dat_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mer_q   <= 1'b0;
         ier_q   <= '0;
         itr_q   <= '0;
         ipr_q   <= '0;
         int_s_q <= '0;
         int_p_q <= '0;
         dat_q   <= '0;
         ack_q   <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         mer_q   <= mer_d;
         ier_q   <= ier_d;
         itr_q   <= itr_d;
         ipr_q   <= ipr_d;
         int_s_q <= int_i;
         int_p_q <= int_s_q;
         dat_q   <= dat_d;
         ack_q   <= ack_d;
         irq_q   <= irq_d;
      end
   end

   assign sa_dat_o = dat_q;
   assign sa_ack_o = ack_q;
   assign sa_err_o = 1'b0;
   assign sa_rty_o = 1'b0;
   assign irq      = irq_q;

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  int_i = '0;
   logic [31:0] sa_dat_i = '0;
   logic [3:0]  sa_sel_i = 4'hF;
   logic [2:0]  sa_addr_i = '0;
   logic [2:0]  sa_tag_i = '0;
   logic        sa_stb_i = 1'b0;
   logic        sa_cyc_i = 1'b0;
   logic        sa_we_i = 1'b0;
   logic [31:0] sa_dat_o;
   logic        sa_ack_o, sa_err_o, sa_rty_o, irq;

   int total = 0;
   int bad = 0;

   irq_ctrl dut (
      .clk(clk), .reset(reset), .int_i(int_i),
      .sa_dat_i(sa_dat_i), .sa_sel_i(sa_sel_i), .sa_addr_i(sa_addr_i),
      .sa_tag_i(sa_tag_i), .sa_stb_i(sa_stb_i), .sa_cyc_i(sa_cyc_i),
      .sa_we_i(sa_we_i), .sa_dat_o(sa_dat_o), .sa_ack_o(sa_ack_o),
      .sa_err_o(sa_err_o), .sa_rty_o(sa_rty_o), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Called at a negedge; one active cycle plus one idle cycle so every
   // strobe gets its own ack.
   task automatic wb_write(input logic [2:0] addr, input logic [31:0] data);
      sa_addr_i = addr; sa_dat_i = data;
      sa_we_i = 1'b1; sa_stb_i = 1'b1; sa_cyc_i = 1'b1;
      tick();
      sa_stb_i = 1'b0; sa_cyc_i = 1'b0; sa_we_i = 1'b0;
      tick();
   endtask

   task automatic wb_read(input string tag, input logic [2:0] addr, input logic [31:0] exp);
      sa_addr_i = addr; sa_we_i = 1'b0; sa_stb_i = 1'b1; sa_cyc_i = 1'b1;
      tick();
      check({tag, "_ack"}, {31'd0, sa_ack_o}, 32'd1);
      check(tag, sa_dat_o, exp);
      sa_stb_i = 1'b0; sa_cyc_i = 1'b0;
      tick();
      check({tag, "_ack_drop"}, {31'd0, sa_ack_o}, 32'd0);
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      check("rst_irq", {31'd0, irq}, 32'd0);
      check("rst_ack", {31'd0, sa_ack_o}, 32'd0);
      check("rst_dat", sa_dat_o, 32'd0);
      check("rst_err_rty", {30'd0, sa_err_o, sa_rty_o}, 32'd0);
      reset = 1'b0;
      tick();
      for (int a = 0; a < 7; a++) wb_read($sformatf("rst_rd%0d", a), 3'(a), 32'd0);

      // Single edge pulse on source 2
      wb_write(3'd5, 32'hF);
      wb_write(3'd1, 32'h4);
      wb_write(3'd0, 32'h1);
      int_i = 4'h4;
      tick();                      // int_s set
      int_i = 4'h0;
      tick();                      // IPR set
      check("e2_irq_early", {31'd0, irq}, 32'd0);
      tick();                      // irq set
      check("e2_irq", {31'd0, irq}, 32'd1);
      wb_read("e2_ipr", 3'd3, 32'h4);
      wb_read("e2_isr", 3'd4, 32'h4);
      wb_read("e2_ivr", 3'd6, 32'h8000_0002);
      wb_write(3'd2, 32'h4);
      check("e2_irq_clr", {31'd0, irq}, 32'd0);
      wb_read("e2_ipr_clr", 3'd3, 32'h0);
      wb_read("e2_ivr_clr", 3'd6, 32'h0);

      // Priority between sources 3 and 1
      wb_write(3'd1, 32'hF);
      int_i = 4'hA;
      tick();
      int_i = 4'h0;
      tick();
      tick();
      wb_read("pri_ipr", 3'd3, 32'hA);
      wb_read("pri_ivr1", 3'd6, 32'h8000_0001);
      wb_write(3'd2, 32'h2);
      wb_read("pri_ivr3", 3'd6, 32'h8000_0003);
      wb_write(3'd2, 32'h8);
      wb_read("pri_ipr_clr", 3'd3, 32'h0);

      // Level source 0
      wb_write(3'd5, 32'h0);
      wb_write(3'd1, 32'h1);
      wb_read("lvl_itr", 3'd5, 32'h0);
      int_i = 4'h1;
      tick();
      tick();
      tick();
      check("lvl_irq", {31'd0, irq}, 32'd1);
      wb_write(3'd2, 32'h1);
      wb_read("lvl_ipr_iar", 3'd3, 32'h1);
      int_i = 4'h0;
      tick();
      tick();
      check("lvl_irq_hold", {31'd0, irq}, 32'd1);
      tick();
      check("lvl_irq_drop", {31'd0, irq}, 32'd0);
      wb_read("lvl_ipr_drop", 3'd3, 32'h0);

      // Master enable gating and set-beats-clear
      wb_write(3'd0, 32'h0);
      wb_write(3'd5, 32'hF);
      wb_write(3'd1, 32'h2);
      int_i = 4'h2;
      tick();
      int_i = 4'h0;
      tick();
      tick();
      check("mer_irq_off", {31'd0, irq}, 32'd0);
      wb_read("mer_ipr", 3'd3, 32'h2);
      wb_read("mer_rd", 3'd0, 32'h0);
      wb_write(3'd0, 32'h1);
      check("mer_irq_on", {31'd0, irq}, 32'd1);
      wb_write(3'd2, 32'h2);
      wb_read("sbc_pre", 3'd3, 32'h0);
      int_i = 4'h2;
      tick();                      // int_s set; rise active until next edge
      sa_addr_i = 3'd2; sa_dat_i = 32'h2; sa_we_i = 1'b1; sa_stb_i = 1'b1;
      int_i = 4'h0;
      tick();                      // IAR clear and rise on the same edge
      sa_stb_i = 1'b0; sa_we_i = 1'b0;
      tick();
      wb_read("sbc_ipr", 3'd3, 32'h2);
      check("sbc_irq", {31'd0, irq}, 32'd1);

      // Held edge input does not re-set after clear
      int_i = 4'h2;
      tick();
      tick();
      tick();
      wb_write(3'd2, 32'h2);
      tick();
      wb_read("hold_ipr", 3'd3, 32'h0);
      int_i = 4'h0;
      tick();

      // Asynchronous reset during active irq and strobe
      int_i = 4'h2;
      tick();
      int_i = 4'h0;
      tick();
      tick();
      check("ar_irq_pre", {31'd0, irq}, 32'd1);
      wb_read("ar_ipr_pre", 3'd3, 32'h2);
      sa_addr_i = 3'd3; sa_we_i = 1'b0; sa_stb_i = 1'b1;
      #2 reset = 1'b1;
      #1;
      check("ar_irq", {31'd0, irq}, 32'd0);
      check("ar_ack", {31'd0, sa_ack_o}, 32'd0);
      check("ar_dat", sa_dat_o, 32'd0);
      tick();
      check("ar_ack_held", {31'd0, sa_ack_o}, 32'd0);
      sa_stb_i = 1'b0;
      reset = 1'b0;
      tick();
      for (int a = 0; a < 7; a++) wb_read($sformatf("ar_rd%0d", a), 3'(a), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
